// File: rtl/axi_rw_arbiter.sv
// axi_rw_arbiter: shares one m_axi_ctrl user interface between NUM_CH requesters.
// Write and read directions are arbitrated independently, one burst outstanding each.
// The default build arbitrates round-robin. Defining AXI_ARB_FIXED_PRIO_EN switches
// both directions to fixed priority, where the lowest index wins.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   req_wr_* / req_rd_*          per-channel request side; address, length and data are packed
//   req_wr_ready/_done, req_rd_vld/_done  routed to the granted channel only
//   req_rd_data                  read data, broadcast to all channels
//   req_ovf                      sticky per-channel flag: a request was dropped
//   m_wr_* / m_rd_*              single controller-side interface
module axi_rw_arbiter #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LEN_W  = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_CH-1:0]          req_wr_start,
    input  logic [NUM_CH*ADDR_W-1:0]   req_wr_addr,
    input  logic [NUM_CH*LEN_W-1:0]    req_wr_len,
    input  logic [NUM_CH*DATA_W-1:0]   req_wr_data,
    output logic [NUM_CH-1:0]          req_wr_ready,
    output logic [NUM_CH-1:0]          req_wr_done,
    input  logic [NUM_CH-1:0]          req_rd_start,
    input  logic [NUM_CH*ADDR_W-1:0]   req_rd_addr,
    input  logic [NUM_CH*LEN_W-1:0]    req_rd_len,
    output logic [DATA_W-1:0]          req_rd_data,
    output logic [NUM_CH-1:0]          req_rd_vld,
    output logic [NUM_CH-1:0]          req_rd_done,
    output logic [NUM_CH-1:0]          req_ovf,
    output logic                       m_wr_start,
    output logic [ADDR_W-1:0]          m_wr_addr,
    output logic [LEN_W-1:0]           m_wr_len,
    output logic [DATA_W-1:0]          m_wr_data,
    input  logic                       m_wr_ready,
    input  logic                       m_wr_done,
    output logic                       m_rd_start,
    output logic [ADDR_W-1:0]          m_rd_addr,
    output logic [LEN_W-1:0]           m_rd_len,
    input  logic [DATA_W-1:0]          m_rd_data,
    input  logic                       m_rd_vld,
    input  logic                       m_rd_done
);

    localparam int unsigned GW = $clog2(NUM_CH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2
    } state_t;

`ifdef AXI_ARB_FIXED_PRIO_EN
    // Lowest pending index wins.
    function automatic logic [GW-1:0] pick(input logic [NUM_CH-1:0] pend);
        logic [GW-1:0] c;
        logic [GW-1:0] w;
        logic          found;
        c     = '0;
        w     = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (!found && pend[c]) begin
                w     = c;
                found = 1'b1;
            end
            c = c + GW'(1);
        end
        return w;
    endfunction
`else
    // Search starts one past the last grant; explicit wrap handles non-power-of-2 NUM_CH.
    function automatic logic [GW-1:0] pick(input logic [NUM_CH-1:0] pend,
                                           input logic [GW-1:0]     last);
        logic [GW-1:0] c;
        logic [GW-1:0] w;
        logic          found;
        c     = last;
        w     = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            c = (c == GW'(NUM_CH - 1)) ? '0 : c + GW'(1);
            if (!found && pend[c]) begin
                w     = c;
                found = 1'b1;
            end
        end
        return w;
    endfunction
`endif

    logic [NUM_CH-1:0] wr_pend, rd_pend;
    logic [NUM_CH-1:0] wr_clr,  rd_clr;
    logic [ADDR_W-1:0] wr_addr_q [NUM_CH];
    logic [LEN_W-1:0]  wr_len_q  [NUM_CH];
    logic [ADDR_W-1:0] rd_addr_q [NUM_CH];
    logic [LEN_W-1:0]  rd_len_q  [NUM_CH];

    state_t            wr_state, wr_state_next;
    state_t            rd_state, rd_state_next;
    logic [GW-1:0]     wr_grant, rd_grant;
    logic [GW-1:0]     wr_win,   rd_win;
`ifndef AXI_ARB_FIXED_PRIO_EN
    logic [GW-1:0]     wr_last,  rd_last;
`endif

`ifdef AXI_ARB_FIXED_PRIO_EN
    assign wr_win = pick(wr_pend);
    assign rd_win = pick(rd_pend);
`else
    assign wr_win = pick(wr_pend, wr_last);
    assign rd_win = pick(rd_pend, rd_last);
`endif

    // Request capture: a pulse on an already-pending channel is dropped and flagged.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_pend <= '0;
            rd_pend <= '0;
            req_ovf <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                wr_addr_q[i] <= '0;
                wr_len_q[i]  <= '0;
                rd_addr_q[i] <= '0;
                rd_len_q[i]  <= '0;
            end
        end else begin
            wr_pend <= (wr_pend & ~wr_clr) | (req_wr_start & ~wr_pend);
            rd_pend <= (rd_pend & ~rd_clr) | (req_rd_start & ~rd_pend);
            req_ovf <= req_ovf | (req_wr_start & wr_pend) | (req_rd_start & rd_pend);
            for (int i = 0; i < NUM_CH; i++) begin
                if (req_wr_start[i] && !wr_pend[i]) begin
                    wr_addr_q[i] <= req_wr_addr[i*ADDR_W +: ADDR_W];
                    wr_len_q[i]  <= req_wr_len[i*LEN_W +: LEN_W];
                end
                if (req_rd_start[i] && !rd_pend[i]) begin
                    rd_addr_q[i] <= req_rd_addr[i*ADDR_W +: ADDR_W];
                    rd_len_q[i]  <= req_rd_len[i*LEN_W +: LEN_W];
                end
            end
        end
    end

    // Write FSM state register.
    always_ff @(posedge clk) begin
        if (rst) wr_state <= IDLE;
        else     wr_state <= wr_state_next;
    end

    // Write FSM next state; grant clears the winner's pending bit.
    always_comb begin
        wr_state_next = wr_state;
        wr_clr        = '0;
        case (wr_state)
            IDLE: begin
                if (|wr_pend) begin
                    wr_state_next  = ISSUE;
                    wr_clr[wr_win] = 1'b1;
                end
            end
            ISSUE:   wr_state_next = BUSY;
            BUSY:    if (m_wr_done) wr_state_next = IDLE;
            default: wr_state_next = IDLE;
        endcase
    end

    // Write grant and command registers; start is raised together with entry to ISSUE.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_wr_start <= 1'b0;
            m_wr_addr  <= '0;
            m_wr_len   <= '0;
            wr_grant   <= '0;
`ifndef AXI_ARB_FIXED_PRIO_EN
            wr_last    <= GW'(NUM_CH - 1);
`endif
        end else begin
            m_wr_start <= 1'b0;
            if (wr_state == IDLE && |wr_pend) begin
                m_wr_start <= 1'b1;
                wr_grant   <= wr_win;
                m_wr_addr  <= wr_addr_q[wr_win];
                m_wr_len   <= wr_len_q[wr_win];
            end
`ifndef AXI_ARB_FIXED_PRIO_EN
            if (wr_state == BUSY && m_wr_done) wr_last <= wr_grant;
`endif
        end
    end

    // Read FSM state register.
    always_ff @(posedge clk) begin
        if (rst) rd_state <= IDLE;
        else     rd_state <= rd_state_next;
    end

    // Read FSM next state; grant clears the winner's pending bit.
    always_comb begin
        rd_state_next = rd_state;
        rd_clr        = '0;
        case (rd_state)
            IDLE: begin
                if (|rd_pend) begin
                    rd_state_next  = ISSUE;
                    rd_clr[rd_win] = 1'b1;
                end
            end
            ISSUE:   rd_state_next = BUSY;
            BUSY:    if (m_rd_done) rd_state_next = IDLE;
            default: rd_state_next = IDLE;
        endcase
    end

    // Read grant and command registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_rd_start <= 1'b0;
            m_rd_addr  <= '0;
            m_rd_len   <= '0;
            rd_grant   <= '0;
`ifndef AXI_ARB_FIXED_PRIO_EN
            rd_last    <= GW'(NUM_CH - 1);
`endif
        end else begin
            m_rd_start <= 1'b0;
            if (rd_state == IDLE && |rd_pend) begin
                m_rd_start <= 1'b1;
                rd_grant   <= rd_win;
                m_rd_addr  <= rd_addr_q[rd_win];
                m_rd_len   <= rd_len_q[rd_win];
            end
`ifndef AXI_ARB_FIXED_PRIO_EN
            if (rd_state == BUSY && m_rd_done) rd_last <= rd_grant;
`endif
        end
    end

    // Combinational data/strobe routing to the granted channel.
    assign m_wr_data   = req_wr_data[32'(wr_grant)*DATA_W +: DATA_W];
    assign req_rd_data = m_rd_data;

    always_comb begin
        req_wr_ready = '0;
        req_wr_done  = '0;
        req_rd_vld   = '0;
        req_rd_done  = '0;
        if (wr_state != IDLE) req_wr_ready[wr_grant] = m_wr_ready;
        if (wr_state == BUSY) req_wr_done[wr_grant]  = m_wr_done;
        if (rd_state == BUSY) begin
            req_rd_vld[rd_grant]  = m_rd_vld;
            req_rd_done[rd_grant] = m_rd_done;
        end
    end

endmodule
